adsr_envelope_generator: RTL and testbench

Linear ADSR envelope generator producing the per-voice amplitude word that drives the amplitude downscaler's `amplitude` input. A 16-bit accumulator walks attack/decay/sustain/release on a sample-rate strobe, under control of a note gate. The upper `AMPLITUDE_BITS` of the accumulator form the output, so the downstream stage scales the tone from silence to full scale.

---
 rtl/adsr_envelope_generator.sv | 144 ++++++++++++++
 tb/tb_adsr_envelope_generator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_generator.sv
// ---------------------------------------------------------------------------
// adsr_envelope_generator
//
// Linear ADSR envelope for one voice. A ACC_BITS-wide accumulator walks
// attack / decay / sustain / release on each sample_en strobe under control
// of a note gate. The upper AMPLITUDE_BITS of the accumulator feed the
// amplitude downscaler.
//
// Configuration macro:
//   ADSR_RETRIGGER_RESET_EN  defined   : a gate rise clears acc (hard retrigger)
//                            undefined : a gate rise keeps acc (legato retrigger)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   sample_en      in   one-cycle sample-rate strobe; envelope steps only then
//   gate           in   note on (1) / off (0), sampled every clk
//   attack_step    in   [ACC_BITS]        increment per tick in ATTACK
//   decay_step     in   [ACC_BITS]        decrement per tick in DECAY
//   sustain_level  in   [AMPLITUDE_BITS]  sustain target, left-aligned in acc
//   release_step   in   [ACC_BITS]        decrement per tick in RELEASE
//   amplitude      out  [AMPLITUDE_BITS]  upper bits of the accumulator
//   state          out  [3]               IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active         out                    high whenever state is not IDLE
// ---------------------------------------------------------------------------
module adsr_envelope_generator #(
    parameter int ACC_BITS       = 16,
    parameter int AMPLITUDE_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_en,
    input  logic                      gate,
    input  logic [ACC_BITS-1:0]       attack_step,
    input  logic [ACC_BITS-1:0]       decay_step,
    input  logic [AMPLITUDE_BITS-1:0] sustain_level,
    input  logic [ACC_BITS-1:0]       release_step,
    output logic [AMPLITUDE_BITS-1:0] amplitude,
    output logic [2:0]                state,
    output logic                      active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_e;

    localparam logic [ACC_BITS:0] MAX_EXT = {1'b0, {ACC_BITS{1'b1}}};

    adsr_state_e         state_q;
    logic [ACC_BITS-1:0] acc_q;
    logic                gate_q;

    logic                rise;
    logic                fall;
    logic                fall_taken;
    logic [ACC_BITS-1:0] sustain_acc;
    logic [ACC_BITS:0]   attack_sum;
    logic [ACC_BITS:0]   decay_diff;
    logic                attack_done;
    logic                decay_done;
    logic                release_done;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // A fall only matters while the note is sounding; in IDLE/RELEASE it is
    // ignored outright, so it does not block that cycle's tick either.
    assign fall_taken = fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN);

    // Sustain target left-aligned in the accumulator (low bits zero).
    assign sustain_acc = ACC_BITS'(sustain_level) << (ACC_BITS - AMPLITUDE_BITS);

    // One extra bit exposes attack overflow and decay underflow (borrow).
    assign attack_sum   = {1'b0, acc_q} + {1'b0, attack_step};
    assign decay_diff   = {1'b0, acc_q} - {1'b0, decay_step};
    assign attack_done  = (attack_sum >= MAX_EXT);
    assign decay_done   = decay_diff[ACC_BITS] || (decay_diff[ACC_BITS-1:0] <= sustain_acc);
    assign release_done = (acc_q <= release_step);

    // NOTE: every register here, including the accumulator, is cleared by the
    // async reset so amplitude/active drop to zero without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below uses the
            // pre-edge values of state_q/acc_q/gate_q regardless of order.
            gate_q <= gate;
            if (rise) begin
                state_q <= ATTACK;
`ifdef ADSR_RETRIGGER_RESET_EN
                acc_q   <= '0;
`endif
            end else if (fall_taken) begin
                state_q <= RELEASE;
            end else if (sample_en) begin
                unique case (state_q)
                    IDLE: acc_q <= '0;
                    ATTACK: begin
                        if (attack_done) begin
                            acc_q   <= MAX_EXT[ACC_BITS-1:0];
                            state_q <= DECAY;
                        end else begin
                            acc_q   <= attack_sum[ACC_BITS-1:0];
                        end
                    end
                    DECAY: begin
                        if (decay_done) begin
                            acc_q   <= sustain_acc;
                            state_q <= SUSTAIN;
                        end else begin
                            acc_q   <= decay_diff[ACC_BITS-1:0];
                        end
                    end
                    // Re-loaded every tick so live sustain_level changes track.
                    SUSTAIN: acc_q <= sustain_acc;
                    RELEASE: begin
                        if (release_done) begin
                            acc_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            acc_q   <= acc_q - release_step;
                        end
                    end
                    default: begin
                        acc_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign amplitude = acc_q[ACC_BITS-1 -: AMPLITUDE_BITS];
    assign state     = state_q;
    assign active    = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope_generator.sv
// ---------------------------------------------------------------------------
// tb_adsr_envelope_generator
//
// Directed scenarios followed by randomized gate/strobe/step traffic, all
// compared every cycle against an arithmetic envelope model held here.
// ---------------------------------------------------------------------------
module tb_adsr_envelope_generator;

    logic        clk;
    logic        rst_n;
    logic        sample_en;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [7:0]  sustain_level;
    logic [15:0] release_step;
    logic [7:0]  amplitude;
    logic [2:0]  state;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, phase numbers as in the interface table.
    int m_acc;
    int m_state;
    int m_gate_q;

    localparam int MAX = 65535;

`ifdef ADSR_RETRIGGER_RESET_EN
    localparam int RETRIG_AMP = 8'h00;
`else
    localparam int RETRIG_AMP = 8'h30;
`endif

    adsr_envelope_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .amplitude     (amplitude),
        .state         (state),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc    = 0;
        m_state  = 0;
        m_gate_q = 0;
    endtask

    // One clock edge of the envelope rules, evaluated on the inputs the DUT saw.
    task automatic model_step(input int g, input int se);
        int s_target;
        s_target = int'(sustain_level) * 256;
        if (g == 1 && m_gate_q == 0) begin
            m_state = 1;
`ifdef ADSR_RETRIGGER_RESET_EN
            m_acc = 0;
`endif
        end else if (g == 0 && m_gate_q == 1 && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (se == 1) begin
            case (m_state)
                0: m_acc = 0;
                1: if (m_acc + int'(attack_step) >= MAX) begin
                       m_acc = MAX; m_state = 2;
                   end else m_acc = m_acc + int'(attack_step);
                2: if (m_acc - int'(decay_step) <= s_target) begin
                       m_acc = s_target; m_state = 3;
                   end else m_acc = m_acc - int'(decay_step);
                3: m_acc = s_target;
                4: if (m_acc <= int'(release_step)) begin
                       m_acc = 0; m_state = 0;
                   end else m_acc = m_acc - int'(release_step);
                default: ;
            endcase
        end
        m_gate_q = g;
    endtask

    // Drive one cycle, advance the model, compare all outputs #1 after the edge.
    task automatic cyc(input logic g, input logic se, input string tag);
        gate      = g;
        sample_en = se;
        @(posedge clk);
        model_step(int'(g), int'(se));
        #1;
        check({tag, "_amp"},    int'(amplitude), m_acc / 256);
        check({tag, "_state"},  int'(state),     m_state);
        check({tag, "_active"}, int'(active),    (m_state != 0) ? 1 : 0);
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_amp",    int'(amplitude), 0);
        check("rst_state",  int'(state),     0);
        check("rst_active", int'(active),    0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        sample_en     = 1'b0;
        gate          = 1'b0;
        attack_step   = 16'h1000;
        decay_step    = 16'h0800;
        sustain_level = 8'h80;
        release_step  = 16'h0400;
        model_reset();
        #2;
        check("por_amp",    int'(amplitude), 0);
        check("por_state",  int'(state),     0);
        check("por_active", int'(active),    0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Attack: rise then 16 ticks of 0x1000.
        cyc(1'b1, 1'b1, "atk_rise");
        check("atk_rise_state", int'(state), 1);
        for (int i = 1; i <= 15; i++) cyc(1'b1, 1'b1, "atk");
        check("atk_t15_amp", int'(amplitude), 8'hF0);
        cyc(1'b1, 1'b1, "atk_t16");
        check("atk_t16_amp",   int'(amplitude), 8'hFF);
        check("atk_t16_state", int'(state),     2);

        // Decay from 0xFFFF to sustain 0x80.
        for (int i = 1; i <= 15; i++) cyc(1'b1, 1'b1, "dec");
        check("dec_t15_amp", int'(amplitude), 8'h87);
        cyc(1'b1, 1'b1, "dec_t16");
        check("dec_t16_amp",   int'(amplitude), 8'h80);
        check("dec_t16_state", int'(state),     3);
        sustain_level = 8'h40;
        cyc(1'b1, 1'b1, "sus_track");
        check("sus_track_amp", int'(amplitude), 8'h40);
        sustain_level = 8'h80;
        cyc(1'b1, 1'b1, "sus_back");

        // Release from 0x8000 in 32 ticks of 0x0400.
        cyc(1'b0, 1'b1, "rel_fall");
        check("rel_fall_state", int'(state), 4);
        for (int i = 1; i <= 31; i++) cyc(1'b0, 1'b1, "rel");
        check("rel_t31_amp", int'(amplitude), 8'h04);
        cyc(1'b0, 1'b1, "rel_t32");
        check("rel_t32_amp",    int'(amplitude), 0);
        check("rel_t32_state",  int'(state),     0);
        check("rel_t32_active", int'(active),    0);

        // Retrigger from RELEASE at 0x3000.
        cyc(1'b1, 1'b1, "rtg_rise");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, "rtg_atk");
        cyc(1'b0, 1'b1, "rtg_fall");
        check("rtg_fall_amp", int'(amplitude), 8'h30);
        cyc(1'b1, 1'b1, "rtg_rise2");
        check("rtg_state", int'(state),     1);
        check("rtg_amp",   int'(amplitude), RETRIG_AMP);

        // Strobe every 4th cycle: three strobes add 0x3000.
        for (int i = 0; i < 12; i++) cyc(1'b1, (i % 4) == 3, "strobe");
        check("strobe_amp", int'(amplitude), RETRIG_AMP + 8'h30);
        cyc(1'b0, 1'b1, "edge_strobe");
        check("edge_strobe_state", int'(state),     4);
        check("edge_strobe_amp",   int'(amplitude), RETRIG_AMP + 8'h30);

        // Async reset mid-ATTACK at 0x5000, then gate high through deassertion.
        @(posedge clk);
        model_step(0, 0);
        #1;
        async_reset_pulse();
        cyc(1'b1, 1'b1, "pre_rst_rise");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, "pre_rst_atk");
        check("pre_rst_amp", int'(amplitude), 8'h50);
        #2;
        async_reset_pulse();
        cyc(1'b1, 1'b1, "post_rst_rise");
        check("post_rst_state", int'(state), 1);

        // Randomized traffic.
        begin
            logic g;
            g = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if (i % 64 == 0) begin
                    attack_step  = 16'($urandom_range(0, 16'h3000));
                    decay_step   = 16'($urandom_range(0, 16'h2000));
                    release_step = 16'($urandom_range(0, 16'h2000));
                    if ($urandom_range(0, 7) == 0) attack_step  = 16'h0000;
                    if ($urandom_range(0, 7) == 0) release_step = 16'hFFFF;
                end
                if (i % 97 == 0)
                    sustain_level = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                if ($urandom_range(0, 29) == 0) g = ~g;
                cyc(g, $urandom_range(0, 3) != 0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
